acc_responder: RTL

- Accelerator-side endpoint of the CVA6 accelerator request/response interface. Sits opposite the core's accelerator dispatcher.
- Accepts non-speculative accelerator_req_t requests into a small queue and decodes custom-0 instructions.
- Executes each request on a fixed-latency integer datapath and returns accelerator_resp_t responses strictly in order.
- Used as the reference accelerator for bring-up and for interface verification.

---
 rtl/acc_responder_pkg.sv | 32 +++
 rtl/acc_responder_if.sv | 22 ++
 rtl/acc_responder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/acc_responder_pkg.sv
// Payload types for the CVA6 accelerator request/response interface.
package acc_responder_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 4;

    localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SUB  = 3'd1;
    localparam logic [2:0] F3_XOR  = 3'd2;
    localparam logic [2:0] F3_MIN  = 3'd3;
    localparam logic [2:0] F3_POPC = 3'd4;
    localparam logic [2:0] F3_ACC  = 3'd5;
    localparam logic [2:0] F3_SYNC = 3'd6;

    typedef struct packed {
        logic [31:0]              insn;
        logic [XLEN-1:0]          rs1;
        logic [XLEN-1:0]          rs2;
        logic [2:0]               frm;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic                     store_pending;
    } accelerator_req_t;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [XLEN-1:0]          result;
        logic                     error;
    } accelerator_resp_t;

endpackage

// File: rtl/acc_responder_if.sv
// Request/response handshake bundle between the core dispatcher and an accelerator.
interface acc_responder_if;
    import acc_responder_pkg::*;

    accelerator_req_t  acc_req;
    logic              acc_req_valid;
    logic              acc_req_ready;
    accelerator_resp_t acc_resp;
    logic              acc_resp_valid;
    logic              acc_resp_ready;

    modport master (
        output acc_req, acc_req_valid, acc_resp_ready,
        input  acc_req_ready, acc_resp, acc_resp_valid
    );

    modport slave (
        input  acc_req, acc_req_valid, acc_resp_ready,
        output acc_req_ready, acc_resp, acc_resp_valid
    );

endinterface

// File: rtl/acc_responder.sv
// Reference accelerator: queues custom-0 requests, executes them on a
// fixed-latency integer datapath and answers strictly in order.
module acc_responder
    import acc_responder_pkg::*;
#(
    parameter int unsigned ReqDepth    = 2,
    parameter int unsigned ExecLatency = 3
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    acc_responder_if.slave acc
);

    localparam int unsigned PtrW = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
    localparam int unsigned OccW = $clog2(ReqDepth + 1);
    localparam int unsigned CntW = $clog2(ExecLatency + 1);

    // Only the decoded fields survive into the queue; frm and rd are never needed.
    typedef struct packed {
        logic                     opcode_ok;
        logic [2:0]               funct3;
        logic [XLEN-1:0]          rs1;
        logic [XLEN-1:0]          rs2;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } q_entry_t;

    typedef enum logic [1:0] {IDLE, EXEC, RESP, DRAIN} state_e;

    q_entry_t          mem_q [ReqDepth];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OccW-1:0]   occ_q, occ_d;
    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    accelerator_resp_t resp_q, resp_d;
    logic              resp_valid_q, resp_valid_d;

    logic              full_c, empty_c, sync_stall_c, ready_c, push_c;
    logic              pop, flush;
    q_entry_t          push_entry_c, head_c;
    logic [XLEN-1:0]   op_result, acc_sum;
    logic              op_legal;
    logic              unused_req_bits;

    function automatic logic [XLEN-1:0] popcount(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] n;
        n = '0;
        for (int i = 0; i < int'(XLEN); i++) begin
            n = n + XLEN'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(ReqDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign unused_req_bits = ^{acc.acc_req.frm, acc.acc_req.insn[31:15], acc.acc_req.insn[11:7]};

    // Request acceptance: SYNC waits for outstanding stores, DRAIN refuses everything.
    always_comb begin
        full_c       = (occ_q == OccW'(ReqDepth));
        empty_c      = (occ_q == '0);
        sync_stall_c = acc.acc_req_valid
                    && (acc.acc_req.insn[6:0] == OPCODE_CUSTOM0)
                    && (acc.acc_req.insn[14:12] == F3_SYNC)
                    && acc.acc_req.store_pending;
        ready_c      = !full_c && !sync_stall_c && (state_q != DRAIN);
        push_c       = acc.acc_req_valid && ready_c;

        push_entry_c.opcode_ok = (acc.acc_req.insn[6:0] == OPCODE_CUSTOM0);
        push_entry_c.funct3    = acc.acc_req.insn[14:12];
        push_entry_c.rs1       = acc.acc_req.rs1;
        push_entry_c.rs2       = acc.acc_req.rs2;
        push_entry_c.trans_id  = acc.acc_req.trans_id;

        head_c = mem_q[rd_ptr_q];
    end

    // Integer datapath on the queue head.
    always_comb begin
        op_result = '0;
        op_legal  = head_c.opcode_ok;
        acc_sum   = acc_q + head_c.rs1;
        unique case (head_c.funct3)
            F3_ADD:  op_result = head_c.rs1 + head_c.rs2;
            F3_SUB:  op_result = head_c.rs1 - head_c.rs2;
            F3_XOR:  op_result = head_c.rs1 ^ head_c.rs2;
            F3_MIN:  op_result = ($signed(head_c.rs1) < $signed(head_c.rs2)) ? head_c.rs1 : head_c.rs2;
            F3_POPC: op_result = popcount(head_c.rs1);
            F3_ACC:  op_result = acc_sum;
            F3_SYNC: op_result = '0;
            default: op_legal  = 1'b0;
        endcase
        if (!op_legal) begin
            op_result = '0;
        end
    end

    // Next-state logic for the FSM, queue pointers, accumulator and response.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        resp_d       = resp_q;
        resp_valid_d = resp_valid_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        occ_d        = occ_q;
        pop          = 1'b0;
        flush        = 1'b0;

        unique case (state_q)
            IDLE: pop = !empty_c;
            EXEC: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end
            end
            RESP: begin
                if (acc.acc_resp_ready) begin
                    resp_valid_d = 1'b0;
                    if (resp_q.error) begin
                        flush   = 1'b1;
                        state_d = DRAIN;
                    end else if (!empty_c) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Dequeue: latch the response payload now, release it after the latency.
        if (pop) begin
            resp_d.trans_id = head_c.trans_id;
            resp_d.result   = op_result;
            resp_d.error    = !op_legal;
            if (op_legal && (head_c.funct3 == F3_ACC)) begin
                acc_d = acc_sum;
            end
            if (op_legal && (ExecLatency > 1)) begin
                state_d = EXEC;
                cnt_d   = CntW'(ExecLatency - 1);
            end else begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
        end

        // An error response empties the queue, including a same-cycle push.
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)    rd_ptr_d = ptr_inc(rd_ptr_q);
            occ_d = occ_q + OccW'(push_c) - OccW'(pop);
        end
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            occ_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            resp_q       <= resp_d;
            resp_valid_q <= resp_valid_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            occ_q        <= occ_d;
        end
    end

    // Queue storage; occupancy alone decides validity, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push_c && !flush) begin
            mem_q[wr_ptr_q] <= push_entry_c;
        end
    end

    assign acc.acc_req_ready  = ready_c;
    assign acc.acc_resp       = resp_q;
    assign acc.acc_resp_valid = resp_valid_q;

endmodule
